alu_result_stage: RTL

- Registered stage directly downstream of the arithmetic ALU. Captures the 16-bit result and the O/C/S/Z flags.
- Maintains the architectural flag register and evaluates branch condition codes against it.
- Buffers results in a 2-entry skid queue and presents them to register-file writeback with a valid/ready handshake.

---
 rtl/alu_result_stage_pkg.sv | 91 +++++++++
 rtl/alu_result_stage_fifo2.sv | 76 +++++++
 rtl/alu_result_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_result_stage_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU result stage: opcode values of
//               the flag-producing ALU operations, flag bit positions inside
//               the {O,C,S,Z} flag vector, the branch condition-code encoding,
//               and helpers to classify opcodes and evaluate conditions.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Opcodes whose results define new architectural flags.
    localparam logic [4:0] ADD    = 5'b00000;
    localparam logic [4:0] ADDINC = 5'b00001;
    localparam logic [4:0] INC    = 5'b00011;
    localparam logic [4:0] SUBDEC = 5'b00100;
    localparam logic [4:0] SUB    = 5'b00101;
    localparam logic [4:0] DEC    = 5'b00110;

    // Bit positions inside the packed {O,C,S,Z} flag vector.
    localparam int FLAG_O = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_Z = 0;

    // Branch condition codes.
    typedef enum logic [3:0] {
        COND_NEVER = 4'd0,
        COND_Z     = 4'd1,
        COND_NZ    = 4'd2,
        COND_S     = 4'd3,
        COND_NS    = 4'd4,
        COND_C     = 4'd5,
        COND_NC    = 4'd6,
        COND_O     = 4'd7,
        COND_NO    = 4'd8,
        COND_LT    = 4'd9,
        COND_GE    = 4'd10,
        COND_LE    = 4'd11,
        COND_GT    = 4'd12,
        COND_RSV13 = 4'd13,
        COND_RSV14 = 4'd14,
        COND_RSV15 = 4'd15
    } cond_e;

    // True when the opcode produces flags that must be latched.
    function automatic logic is_flag_op(input logic [4:0] op);
        logic r;
        case (op)
            ADD, ADDINC, INC, SUBDEC, SUB, DEC: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Evaluate a condition code against a {O,C,S,Z} flag vector.
    function automatic logic eval_cond(input logic [3:0] flags, input logic [3:0] cond);
        logic o;
        logic c;
        logic s;
        logic z;
        logic lt;
        logic r;
        o  = flags[FLAG_O];
        c  = flags[FLAG_C];
        s  = flags[FLAG_S];
        z  = flags[FLAG_Z];
        // Signed less-than: sign disagrees with overflow.
        lt = s ^ o;
        case (cond_e'(cond))
            COND_Z:  r = z;
            COND_NZ: r = ~z;
            COND_S:  r = s;
            COND_NS: r = ~s;
            COND_C:  r = c;
            COND_NC: r = ~c;
            COND_O:  r = o;
            COND_NO: r = ~o;
            COND_LT: r = lt;
            COND_GE: r = ~lt;
            COND_LE: r = z | lt;
            COND_GT: r = ~z & ~lt;
            default: r = 1'b0;   // never, and reserved codes 13..15
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_stage_fifo2.sv
// ============================================================================
// Module      : result_fifo2
// Description : Two-entry skid queue with valid/ready handshakes on both
//               sides. Slot 0 always holds the head entry. Input readiness is
//               derived from the registered occupancy only, so there is no
//               combinational path from out_ready to in_ready.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               in_valid/ready  - producer handshake, in_data payload
//               out_valid/ready - consumer handshake, out_data head payload
//                                 (zero when empty)
// Parameters  : WIDTH - payload width in bits
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_fifo2 #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count < 2'd2) & rst_n;
    assign out_valid = (r_count != 2'd0);
    // Slots keep stale data after a pop, so the head is masked when empty.
    assign out_data  = out_valid ? r_slot0 : '0;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= in_data;
                    end else begin
                        r_slot1 <= in_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push needs count<2 and pop needs count>=1, so the queue
                    // holds exactly one entry: the newcomer replaces the head.
                    r_slot0 <= in_data;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module      : alu_result_stage
// Description : Registered stage behind the ALU. Queues {result, rd, we} in a
//               two-entry skid queue towards register-file writeback, keeps
//               the architectural {O,C,S,Z} flag register (updated when a
//               flag-producing opcode is accepted) and evaluates branch
//               condition codes against it.
// Ports       : clk, rst_n                 - clock, sync active-low reset
//               in_valid/in_ready          - ALU-side handshake
//               in_op, in_resu, in_o/c/s/z - opcode, result, ALU flags
//               in_rd, in_we               - destination and write enable
//               out_valid/out_ready        - writeback handshake
//               out_data, out_rd, out_we   - head entry (zero when empty)
//               flags                      - architectural flags {O,C,S,Z}
//               cond / cond_true           - condition code and its result
// Parameters  : BITS - datapath width, RD_W - register address width
// Macros      : ALU_FLAG_BYPASS_EN - when defined, cond_true sees the incoming
//               ALU flags in the cycle a flag-producing opcode is accepted.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
    parameter int BITS = 16,
    parameter int RD_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [BITS-1:0] in_resu,
    input  logic            in_o,
    input  logic            in_c,
    input  logic            in_s,
    input  logic            in_z,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_we,
    output logic [3:0]      flags,
    input  logic [3:0]      cond,
    output logic            cond_true
);

    import alu_pkg::*;

    localparam int PAYLOAD_W = BITS + RD_W + 1;

    logic [PAYLOAD_W-1:0] w_in_payload;
    logic [PAYLOAD_W-1:0] w_out_payload;
    logic [3:0]           w_in_flags;
    logic [3:0]           w_cond_flags;
    logic                 w_accept;
    logic                 w_flag_upd;
    logic [3:0]           r_flags;

    // ------------------------------------------------------------------
    // Writeback queue
    // ------------------------------------------------------------------
    assign w_in_payload = {in_resu, in_rd, in_we};

    result_fifo2 #(
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign out_data = w_out_payload[PAYLOAD_W-1 -: BITS];
    assign out_rd   = w_out_payload[RD_W:1];
    assign out_we   = w_out_payload[0];

    // ------------------------------------------------------------------
    // Architectural flags: latched at accept, not at writeback pop
    // ------------------------------------------------------------------
    assign w_in_flags = {in_o, in_c, in_s, in_z};
    assign w_accept   = in_valid & in_ready;
    assign w_flag_upd = w_accept & is_flag_op(in_op);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_flag_upd) begin
            r_flags <= w_in_flags;
        end
    end

    assign flags = r_flags;

    // ------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------
`ifdef ALU_FLAG_BYPASS_EN
    // Forward the flags being latched this cycle so a branch directly after
    // a compare resolves without waiting for the register update.
    assign w_cond_flags = w_flag_upd ? w_in_flags : r_flags;
`else
    assign w_cond_flags = r_flags;
`endif

    assign cond_true = eval_cond(w_cond_flags, cond);

endmodule

`default_nettype wire
